// File: rtl/rtc_pkg.sv
// Shared constants and BCD helpers for the time-of-day counter.
//   BCD_MAX_*   : inclusive upper bounds of the seconds/minutes fields
//   HOUR_*      : hour range limits for the 24h and 12h formats
//   RST_HH_*    : hour value restored by reset for each format
//   bcd_valid() : both nibbles are decimal digits and the value is <= max
//   bcd_inc()   : two-digit BCD increment; the caller handles field wrap
package rtc_pkg;

  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] HOUR_MAX_24  = 8'h23;
  localparam logic [7:0] HOUR_MIN_12  = 8'h01;
  localparam logic [7:0] HOUR_MAX_12  = 8'h12;
  // In 12h mode the pm flag flips when the hour steps from 11 to 12.
  localparam logic [7:0] HOUR_PM_FLIP = 8'h11;

  localparam logic [7:0] RST_HH_24 = 8'h00;
  localparam logic [7:0] RST_HH_12 = 8'h12;
  localparam logic [7:0] RST_MM    = 8'h00;
  localparam logic [7:0] RST_SS    = 8'h00;

  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
    return (val[3:0] <= 4'd9) && (val[7:4] <= 4'd9) && (val <= max);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] val);
    if (val[3:0] == 4'd9) begin
      return {val[7:4] + 4'd1, 4'd0};
    end
    return {val[7:4], val[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter used for the seconds and minutes fields.
//   clk_ht, rst_n : clock and asynchronous active-low reset (resets to 00)
//   inc           : advance by one; wraps max -> 00
//   load/load_val : parallel load, takes priority over inc
//   max           : inclusive wrap point (BCD)
//   q             : current value
//   carry         : combinational, high when inc is applied at max
module bcd2_counter
  import rtc_pkg::*;
(
  input  logic       clk_ht,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic [7:0] max,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] r_q;
  logic [7:0] w_q_next;

  // Combinational so the carry ripples into the next field in the same cycle.
  assign carry = inc & ~load & (r_q == max);

  always_comb begin
    w_q_next = r_q;
    if (load) begin
      w_q_next = load_val;
    end else if (inc) begin
      w_q_next = (r_q == max) ? 8'h00 : bcd_inc(r_q);
    end
  end

  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RST_SS;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/rtc_hms_counter.sv
// Time-of-day counter clocked by clk_ht, advanced by rising edges of the 1 Hz clk_di.
//   clk_ht, rst_n            : system clock, asynchronous active-low reset
//   clk_di                   : 1 Hz square wave, edge-detected in the clk_ht domain
//   run                      : 1 = count, 0 = hold (edges are dropped, not queued)
//   set_load, set_hh/mm/ss/pm: single-cycle validated time load
//   hh_bcd, mm_bcd, ss_bcd   : packed BCD time; pm flag (0 in 24h mode)
//   sec_tick, day_tick       : one-cycle pulses aligned with the updated time
//   set_err                  : one-cycle pulse when a load is rejected
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter bit H24 = 1'b1
) (
  input  logic       clk_ht,
  input  logic       rst_n,
  input  logic       clk_di,
  input  logic       run,
  input  logic       set_load,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       set_err
);

  logic       r_clk_di_q;
  logic [7:0] r_hh;
  logic       r_pm;
  logic       r_sec_tick;
  logic       r_day_tick;
  logic       r_set_err;

  logic       w_rise;
  logic       w_tick;
  logic       w_hh_valid;
  logic       w_set_valid;
  logic       w_load_ok;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic [7:0] w_hh_next;
  logic       w_pm_next;
  logic       w_day;

  assign w_rise = clk_di & ~r_clk_di_q;
  // A load in the same cycle as an edge swallows the edge, accepted or not.
  assign w_tick = w_rise & run & ~set_load;

  assign w_hh_valid  = H24 ? bcd_valid(set_hh, HOUR_MAX_24)
                           : (bcd_valid(set_hh, HOUR_MAX_12) && (set_hh >= HOUR_MIN_12));
  assign w_set_valid = bcd_valid(set_ss, BCD_MAX_SEC) && bcd_valid(set_mm, BCD_MAX_MIN)
                       && w_hh_valid;
  assign w_load_ok   = set_load & w_set_valid;

  bcd2_counter u_sec (
    .clk_ht   (clk_ht),
    .rst_n    (rst_n),
    .inc      (w_tick),
    .load     (w_load_ok),
    .load_val (set_ss),
    .max      (BCD_MAX_SEC),
    .q        (ss_bcd),
    .carry    (w_sec_carry)
  );

  bcd2_counter u_min (
    .clk_ht   (clk_ht),
    .rst_n    (rst_n),
    .inc      (w_sec_carry),
    .load     (w_load_ok),
    .load_val (set_mm),
    .max      (BCD_MAX_MIN),
    .q        (mm_bcd),
    .carry    (w_min_carry)
  );

  always_comb begin
    w_hh_next = r_hh;
    w_pm_next = r_pm;
    w_day     = 1'b0;
    if (w_load_ok) begin
      w_hh_next = set_hh;
      w_pm_next = H24 ? 1'b0 : set_pm;
    end else if (w_min_carry) begin
      if (H24) begin
        if (r_hh == HOUR_MAX_24) begin
          w_hh_next = 8'h00;
          w_day     = 1'b1;
        end else begin
          w_hh_next = bcd_inc(r_hh);
        end
      end else begin
        if (r_hh == HOUR_MAX_12) begin
          // 12 -> 01 keeps the am/pm half.
          w_hh_next = HOUR_MIN_12;
        end else begin
          w_hh_next = bcd_inc(r_hh);
          if (r_hh == HOUR_PM_FLIP) begin
            w_pm_next = ~r_pm;
            // Leaving pm for am is midnight.
            w_day     = r_pm;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      // Start high so a clk_di already high at release is not seen as an edge.
      r_clk_di_q <= 1'b1;
      r_hh       <= H24 ? RST_HH_24 : RST_HH_12;
      r_pm       <= 1'b0;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_clk_di_q <= clk_di;
      r_hh       <= w_hh_next;
      r_pm       <= w_pm_next;
      r_sec_tick <= w_tick;
      r_day_tick <= w_day;
      r_set_err  <= set_load & ~w_set_valid;
    end
  end

  assign hh_bcd   = r_hh;
  assign pm       = H24 ? 1'b0 : r_pm;
  assign sec_tick = r_sec_tick;
  assign day_tick = r_day_tick;
  assign set_err  = r_set_err;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Directed self-checking bench: one 24h instance (a) and one 12h instance (b) share stimulus.
module tb_rtc_hms_counter;

  logic       clk_ht = 1'b0;
  logic       rst_n;
  logic       clk_di;
  logic       run;
  logic       set_load;
  logic [7:0] set_hh, set_mm, set_ss;
  logic       set_pm;

  logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
  logic       pm_a, st_a, dt_a, se_a, pm_b, st_b, dt_b, se_b;
  logic [23:0] t_a, t_b;

  int n_tests = 0;
  int n_fail  = 0;
  int sec_cnt_a = 0;
  int cnt_snap;
  // Pulse outputs sampled #1 after the most recent active edge.
  logic cap_st_a, cap_dt_a, cap_se_a, cap_st_b, cap_dt_b, cap_se_b;

  assign t_a = {hh_a, mm_a, ss_a};
  assign t_b = {hh_b, mm_b, ss_b};

  always #4 clk_ht = ~clk_ht;

  always @(negedge clk_ht) begin
    if (st_a) sec_cnt_a <= sec_cnt_a + 1;
  end

  rtc_hms_counter #(.H24(1'b1)) u_dut_a (
    .clk_ht(clk_ht), .rst_n(rst_n), .clk_di(clk_di), .run(run), .set_load(set_load),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
    .hh_bcd(hh_a), .mm_bcd(mm_a), .ss_bcd(ss_a), .pm(pm_a),
    .sec_tick(st_a), .day_tick(dt_a), .set_err(se_a)
  );

  rtc_hms_counter #(.H24(1'b0)) u_dut_b (
    .clk_ht(clk_ht), .rst_n(rst_n), .clk_di(clk_di), .run(run), .set_load(set_load),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
    .hh_bcd(hh_b), .mm_bcd(mm_b), .ss_bcd(ss_b), .pm(pm_b),
    .sec_tick(st_b), .day_tick(dt_b), .set_err(se_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic capture();
    cap_st_a = st_a; cap_dt_a = dt_a; cap_se_a = se_a;
    cap_st_b = st_b; cap_dt_b = dt_b; cap_se_b = se_b;
  endtask

  // One rising edge of clk_di; pulses captured right after the update edge.
  task automatic rise_edge();
    @(negedge clk_ht) clk_di = 1'b1;
    @(posedge clk_ht) #1;
    capture();
    @(negedge clk_ht) clk_di = 1'b0;
    repeat (2) @(negedge clk_ht);
  endtask

  task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                         input logic p);
    @(negedge clk_ht);
    set_hh = hh; set_mm = mm; set_ss = ss; set_pm = p; set_load = 1'b1;
    @(posedge clk_ht) #1;
    capture();
    @(negedge clk_ht) set_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_di = 1'b1; run = 1'b1; set_load = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; set_pm = 1'b0;
    #21 rst_n = 1'b1;
    #1;
    check_eq("rst_time_a", {8'h0, t_a}, 32'h00_000000);
    check_eq("rst_time_b", {8'h0, t_b}, 32'h00_120000);
    check_eq("rst_pm_b", {31'h0, pm_b}, 32'h0);
    check_eq("rst_pulses", {29'h0, st_a, dt_a, se_a}, 32'h0);
    cnt_snap = sec_cnt_a;
    // clk_di held high through release must not count.
    repeat (4) @(negedge clk_ht);
    check_eq("no_tick_at_release", {8'h0, t_a}, 32'h00_000000);
    clk_di = 1'b0;
    repeat (2) @(negedge clk_ht);
    rise_edge();
    check_eq("first_sec_tick", {31'h0, cap_st_a}, 32'h1);
    rise_edge();
    rise_edge();
    check_eq("three_secs_a", {8'h0, t_a}, 32'h00_000003);
    check_eq("three_secs_b", {8'h0, t_b}, 32'h00_120003);
    check_eq("sec_tick_count", sec_cnt_a - cnt_snap, 32'd3);

    // 24h midnight rollover.
    do_load(8'h23, 8'h59, 8'h58, 1'b0);
    check_eq("load_2359_a", {8'h0, t_a}, 32'h00_235958);
    check_eq("load_ok_noerr_a", {31'h0, cap_se_a}, 32'h0);
    check_eq("load_23h_err_b", {31'h0, cap_se_b}, 32'h1);
    rise_edge();
    check_eq("t_235959", {8'h0, t_a}, 32'h00_235959);
    check_eq("no_day_235959", {31'h0, cap_dt_a}, 32'h0);
    rise_edge();
    check_eq("t_midnight_a", {8'h0, t_a}, 32'h00_000000);
    check_eq("day_tick_a", {31'h0, cap_dt_a}, 32'h1);

    // 12h format transitions.
    do_load(8'h11, 8'h59, 8'h59, 1'b0);
    rise_edge();
    check_eq("noon_b", {7'h0, pm_b, t_b}, 32'h01_120000);
    check_eq("noon_no_day_b", {31'h0, cap_dt_b}, 32'h0);
    do_load(8'h12, 8'h59, 8'h59, 1'b1);
    rise_edge();
    check_eq("one_pm_b", {7'h0, pm_b, t_b}, 32'h01_010000);
    do_load(8'h11, 8'h59, 8'h59, 1'b1);
    rise_edge();
    check_eq("midnight_b", {7'h0, pm_b, t_b}, 32'h00_120000);
    check_eq("day_tick_b", {31'h0, cap_dt_b}, 32'h1);

    // Rejected loads leave the time alone.
    do_load(8'h10, 8'h20, 8'h30, 1'b0);
    do_load(8'h24, 8'h00, 8'h00, 1'b0);
    check_eq("err_hh24", {31'h0, cap_se_a}, 32'h1);
    check_eq("hold_hh24", {8'h0, t_a}, 32'h00_102030);
    do_load(8'h01, 8'h60, 8'h00, 1'b0);
    check_eq("err_mm60", {30'h0, cap_se_a, cap_se_b}, 32'h3);
    check_eq("hold_mm60", {8'h0, t_b}, 32'h00_102030);
    do_load(8'h01, 8'h00, 8'h1A, 1'b0);
    check_eq("err_ss1a", {31'h0, cap_se_a}, 32'h1);
    check_eq("hold_ss1a", {8'h0, t_a}, 32'h00_102030);
    do_load(8'h00, 8'h00, 8'h00, 1'b0);
    check_eq("hh00_ok_a_err_b", {30'h0, cap_se_a, cap_se_b}, 32'h1);
    check_eq("hh00_held_b", {8'h0, t_b}, 32'h00_102030);
    @(negedge clk_ht);
    check_eq("err_one_cycle", {31'h0, se_a}, 32'h0);

    // Load coinciding with a rising edge: load wins, edge dropped.
    @(negedge clk_ht);
    clk_di = 1'b1; set_load = 1'b1;
    set_hh = 8'h10; set_mm = 8'h20; set_ss = 8'h30;
    @(posedge clk_ht) #1;
    check_eq("load_vs_rise", {8'h0, t_a}, 32'h00_102030);
    check_eq("load_vs_rise_tick", {31'h0, st_a}, 32'h0);
    @(negedge clk_ht) set_load = 1'b0;
    repeat (2) @(negedge clk_ht);
    check_eq("rise_not_replayed", {8'h0, t_a}, 32'h00_102030);
    clk_di = 1'b0;
    repeat (2) @(negedge clk_ht);
    // Rejected load with a rising edge also drops the edge.
    clk_di = 1'b1; set_load = 1'b1; set_mm = 8'h77;
    @(posedge clk_ht) #1;
    check_eq("bad_load_vs_rise", {8'h0, t_a}, 32'h00_102030);
    @(negedge clk_ht) set_load = 1'b0;
    @(negedge clk_ht) clk_di = 1'b0;
    repeat (2) @(negedge clk_ht);

    // run=0 freezes; edges are not queued.
    run = 1'b0;
    for (int i = 0; i < 5; i++) rise_edge();
    check_eq("frozen", {8'h0, t_a}, 32'h00_102030);
    run = 1'b1;
    repeat (3) @(negedge clk_ht);
    check_eq("no_queued_edges", {8'h0, t_a}, 32'h00_102030);
    rise_edge();
    check_eq("resume", {8'h0, t_a}, 32'h00_102031);

    // Asynchronous reset mid-count, checked before any clock edge.
    rise_edge();
    @(posedge clk_ht) #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_a", {8'h0, t_a}, 32'h00_000000);
    check_eq("async_rst_b", {7'h0, pm_b, t_b}, 32'h00_120000);
    @(negedge clk_ht) rst_n = 1'b1;
    repeat (2) @(negedge clk_ht);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
